// File: rtl/sweep_timer_sequencer_pkg.sv
// Shared definitions for the sweep timer sequencer: timer register map,
// control bit positions, FSM states and the internal bus request.
package sweep_timer_sequencer_pkg;

  localparam logic [2:0] TMR_STATUS   = 3'd0;
  localparam logic [2:0] TMR_CONTROL  = 3'd1;
  localparam logic [2:0] TMR_PERIOD_L = 3'd2;
  localparam logic [2:0] TMR_PERIOD_H = 3'd3;
  localparam logic [2:0] TMR_SNAP_L   = 3'd4;
  localparam logic [2:0] TMR_SNAP_H   = 3'd5;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  typedef enum logic [3:0] {
    ST_IDLE, ST_WR_PL, ST_WR_PH, ST_GAP, ST_WR_CTRL, ST_RUN,
    ST_CLR_ST, ST_IRQ_WAIT, ST_STOP, ST_FIN,
    ST_SNAP_WR, ST_SNAP_RL, ST_SNAP_RH, ST_SNAP_CAP
  } seq_state_e;

  typedef struct packed {
    logic        wr_en;
    logic        rd_en;
    logic [2:0]  addr;
    logic [15:0] data;
  } bus_req_t;

  function automatic logic [15:0] ctrl_word(input logic start, input logic cont,
                                            input logic ito, input logic stop);
    ctrl_word             = '0;
    ctrl_word[CTRL_ITO]   = ito;
    ctrl_word[CTRL_CONT]  = cont;
    ctrl_word[CTRL_START] = start;
    ctrl_word[CTRL_STOP]  = stop;
  endfunction

endpackage

// File: rtl/sweep_timer_sequencer_if.sv
// Run-command handshake plus the Avalon-MM link to the interval timer slave.
interface sweep_timer_sequencer_if #(parameter int CNT_W = 16);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_period;
  logic             cmd_continuous;
  logic [CNT_W-1:0] cmd_count;
  logic [2:0]       tmr_address;
  logic             tmr_chipselect;
  logic             tmr_write_n;
  logic [15:0]      tmr_writedata;
  logic [15:0]      tmr_readdata;
  logic             tmr_irq;

  modport master (
    input  cmd_valid, cmd_period, cmd_continuous, cmd_count, tmr_readdata, tmr_irq,
    output cmd_ready, tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata
  );

  modport slave (
    output cmd_valid, cmd_period, cmd_continuous, cmd_count, tmr_readdata, tmr_irq,
    input  cmd_ready, tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata
  );
endinterface

// File: rtl/sweep_timer_sequencer_tmr_bus.sv
// Turns single-cycle FSM requests into Avalon strobes; tracks which cycle
// carries read data from the timer's registered readdata path.
module sweep_timer_sequencer_tmr_bus
  import sweep_timer_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  bus_req_t    req,
  output logic [2:0]  tmr_address,
  output logic        tmr_chipselect,
  output logic        tmr_write_n,
  output logic [15:0] tmr_writedata,
  input  logic [15:0] tmr_readdata,
  output logic        rd_valid,
  output logic [15:0] rd_data
);

  always_comb begin
    tmr_address    = req.addr;
    tmr_chipselect = req.wr_en | req.rd_en;
    tmr_write_n    = ~req.wr_en;
    tmr_writedata  = req.wr_en ? req.data : 16'h0000;
  end

  // readdata answers the address presented on the previous cycle
  always_ff @(posedge clk) begin
    if (reset) rd_valid <= 1'b0;
    else       rd_valid <= req.rd_en;
  end

  assign rd_data = tmr_readdata;

endmodule

// File: rtl/sweep_timer_sequencer.sv
// Sequencer FSM: programs the interval timer for a run, services its
// interrupts, counts ticks, takes counter snapshots and stops the timer.
module sweep_timer_sequencer
  import sweep_timer_sequencer_pkg::*;
#(
  parameter int MIN_PERIOD = 8,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  sweep_timer_sequencer_if.master tif,
  input  logic                    stop_req,
  input  logic                    snap_req,
  output logic                    tick,
  output logic [CNT_W-1:0]        tick_count,
  output logic                    snap_valid,
  output logic [31:0]             snap_value,
  output logic                    done,
  output logic                    busy
);

  seq_state_e       state, nxt;
  bus_req_t         req;
  logic [31:0]      per_q, per_clamped;
  logic [CNT_W-1:0] n_q, cnt_q;
  logic             cont_q;
  logic [31:0]      snap_q;
  logic             cmd_fire, rd_valid;
  logic [15:0]      rd_data;

  assign tif.cmd_ready = (state == ST_IDLE) & ~reset;
  assign cmd_fire      = tif.cmd_valid & tif.cmd_ready;
  assign per_clamped   = (tif.cmd_period < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) : tif.cmd_period;
  assign busy          = (state != ST_IDLE);
  assign tick_count    = cnt_q;
  // upper half arrives on the bus during the cycle that flags the snapshot
  assign snap_value    = (state == ST_SNAP_CAP) ? {rd_data, snap_q[15:0]} : snap_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      per_q  <= '0;
      n_q    <= '0;
      cont_q <= 1'b0;
      cnt_q  <= '0;
      snap_q <= '0;
    end else begin
      state <= nxt;
      if (cmd_fire) begin
        per_q  <= per_clamped - 32'd1;
        n_q    <= tif.cmd_continuous ? tif.cmd_count : CNT_W'(1);
        cont_q <= tif.cmd_continuous;
        cnt_q  <= '0;
      end
      if (state == ST_CLR_ST) cnt_q <= cnt_q + CNT_W'(1);
      if (state == ST_SNAP_RH  && rd_valid) snap_q[15:0]  <= rd_data;
      if (state == ST_SNAP_CAP && rd_valid) snap_q[31:16] <= rd_data;
    end
  end

  always_comb begin
    nxt        = state;
    req        = '0;
    tick       = 1'b0;
    snap_valid = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE:     if (cmd_fire) nxt = ST_WR_PL;
      ST_WR_PL: begin
        req.wr_en = 1'b1; req.addr = TMR_PERIOD_L; req.data = per_q[15:0];
        nxt = ST_WR_PH;
      end
      ST_WR_PH: begin
        req.wr_en = 1'b1; req.addr = TMR_PERIOD_H; req.data = per_q[31:16];
        nxt = ST_GAP;
      end
      // let the timer's forced reload settle before START
      ST_GAP:      nxt = ST_WR_CTRL;
      ST_WR_CTRL: begin
        req.wr_en = 1'b1; req.addr = TMR_CONTROL;
        req.data  = ctrl_word(1'b1, cont_q, 1'b1, 1'b0);
        nxt = ST_RUN;
      end
      ST_RUN: begin
        if (tif.tmr_irq)  nxt = ST_CLR_ST;
        else if (stop_req) nxt = ST_STOP;
        else if (snap_req) nxt = ST_SNAP_WR;
      end
      ST_CLR_ST: begin
        req.wr_en = 1'b1; req.addr = TMR_STATUS;
        tick = 1'b1;
        nxt  = ST_IRQ_WAIT;
      end
      // irq is still dropping here, so it is not looked at
      ST_IRQ_WAIT: nxt = (n_q != '0 && cnt_q == n_q) ? ST_STOP : ST_RUN;
      ST_STOP: begin
        req.wr_en = 1'b1; req.addr = TMR_CONTROL;
        req.data  = ctrl_word(1'b0, 1'b0, 1'b0, 1'b1);
        nxt = ST_FIN;
      end
      ST_FIN: begin
        done = 1'b1;
        nxt  = ST_IDLE;
      end
      ST_SNAP_WR: begin
        req.wr_en = 1'b1; req.addr = TMR_SNAP_L;
        nxt = ST_SNAP_RL;
      end
      ST_SNAP_RL: begin
        req.rd_en = 1'b1; req.addr = TMR_SNAP_L;
        nxt = ST_SNAP_RH;
      end
      ST_SNAP_RH: begin
        req.rd_en = 1'b1; req.addr = TMR_SNAP_H;
        nxt = ST_SNAP_CAP;
      end
      ST_SNAP_CAP: begin
        snap_valid = 1'b1;
        nxt = ST_RUN;
      end
      default:     nxt = ST_IDLE;
    endcase
  end

  sweep_timer_sequencer_tmr_bus u_bus (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .tmr_address    (tif.tmr_address),
    .tmr_chipselect (tif.tmr_chipselect),
    .tmr_write_n    (tif.tmr_write_n),
    .tmr_writedata  (tif.tmr_writedata),
    .tmr_readdata   (tif.tmr_readdata),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data)
  );

endmodule
